// File: rtl/sitcpxg_tx_arbiter.sv
// rtl/sitcpxg_tx_arbiter.sv - round-robin scheduler sharing the SiTCPXG TCP transmit port
module sitcpxg_tx_arbiter #(
  parameter int NCH       = 4,
  parameter int MAX_BURST = 64
) (
  input  logic                XGMII_CLOCK,
  input  logic                RSTn,
  input  logic                SESSION_EST,
  input  logic                CLOSE_REQ,
  output logic                CLOSE_ACK,
  input  logic                TX_AFULL,
  output logic [63:0]         TX_D,
  output logic [3:0]          TX_B,
  input  logic [NCH-1:0]      CH_VALID,
  input  logic [NCH-1:0]      CH_LAST,
  input  logic [NCH*64-1:0]   CH_D,
  input  logic [NCH*4-1:0]    CH_B,
  output logic [NCH-1:0]      CH_READY,
  output logic [2:0]          GNT_ID,
  output logic                GNT_ACT,
  output logic                ERR_LEN
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN, S_ACK} state_t;

  state_t      state;
  logic [2:0]  ptr;
  logic [7:0]  count;
  logic [7:0]  count_inc;
  logic        burst_done;
  logic [2:0]  win_id;
  logic        win_any;
  logic        sel_valid;
  logic        sel_last;
  logic [63:0] sel_d;
  logic [3:0]  sel_b;
  logic        bad_len;
  logic        accept;

  // Lowest offset from ptr+1 wins, so scan offsets from the far end downwards.
  always_comb begin
    win_id = '0;
    for (int k = NCH; k >= 1; k--) begin
      for (int j = 0; j < NCH; j++) begin
        if (CH_VALID[j] && (j == (int'(ptr) + k) % NCH)) win_id = 3'(j);
      end
    end
  end

  assign win_any = |CH_VALID;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_d     = '0;
    sel_b     = '0;
    for (int i = 0; i < NCH; i++) begin
      if (GNT_ID == 3'(i)) begin
        sel_valid = CH_VALID[i];
        sel_last  = CH_LAST[i];
        sel_d     = CH_D[64*i +: 64];
        sel_b     = CH_B[4*i +: 4];
      end
    end
  end

  assign accept = (state == S_GRANT) && sel_valid && !TX_AFULL && SESSION_EST && !CLOSE_REQ;

  always_comb begin
    CH_READY = '0;
    for (int i = 0; i < NCH; i++) begin
      CH_READY[i] = accept && (GNT_ID == 3'(i));
    end
  end

  assign count_inc  = (count >= 8'(MAX_BURST)) ? count : count + 8'd1;
  assign burst_done = (count_inc == 8'(MAX_BURST));
  assign bad_len    = (sel_b > 4'd8);

  always_ff @(posedge XGMII_CLOCK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= S_IDLE;
      ptr       <= 3'(NCH - 1);
      count     <= '0;
      GNT_ID    <= '0;
      GNT_ACT   <= 1'b0;
      TX_D      <= '0;
      TX_B      <= '0;
      CLOSE_ACK <= 1'b0;
      ERR_LEN   <= 1'b0;
    end else begin
      TX_B <= '0;
      if (accept) begin
        TX_D <= sel_d;
        TX_B <= bad_len ? 4'd0 : sel_b;
        if (bad_len) ERR_LEN <= 1'b1;
      end

      // Session loss overrides everything; close requests override normal arbitration.
      if (!SESSION_EST) begin
        state     <= S_IDLE;
        count     <= '0;
        GNT_ACT   <= 1'b0;
        CLOSE_ACK <= 1'b0;
      end else if (CLOSE_REQ && (state == S_IDLE || state == S_GRANT)) begin
        state   <= S_DRAIN;
        count   <= '0;
        GNT_ACT <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (win_any) begin
              GNT_ID  <= win_id;
              GNT_ACT <= 1'b1;
              state   <= S_GRANT;
            end
          end
          S_GRANT: begin
            if (accept) begin
              if (sel_last || burst_done) begin
                state   <= S_IDLE;
                ptr     <= GNT_ID;
                count   <= '0;
                GNT_ACT <= 1'b0;
              end else begin
                count <= count_inc;
              end
            end
          end
          S_DRAIN: begin
            state     <= S_ACK;
            CLOSE_ACK <= 1'b1;
          end
          S_ACK: begin
            if (!CLOSE_REQ) begin
              state     <= S_IDLE;
              CLOSE_ACK <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sitcpxg_tx_arbiter.sv
// tb/tb_sitcpxg_tx_arbiter.sv - bench for sitcpxg_tx_arbiter with cycle model and directed cases
module tb_sitcpxg_tx_arbiter;
  localparam int NCH = 4;
  localparam int MB  = 4;
  localparam int M_IDLE = 0, M_GRANT = 1, M_DRAIN = 2, M_ACK = 3;

  logic clk = 1'b0;
  logic rst_n, sess, creq, afull;
  logic close_ack;
  logic [63:0] tx_d;
  logic [3:0]  tx_b;
  logic [NCH-1:0] ch_valid, ch_last, ch_ready;
  logic [NCH*64-1:0] ch_d;
  logic [NCH*4-1:0]  ch_b;
  logic [2:0] gnt_id;
  logic gnt_act, err_len;

  always #5 clk = ~clk;

  sitcpxg_tx_arbiter #(.NCH(NCH), .MAX_BURST(MB)) dut (
    .XGMII_CLOCK(clk), .RSTn(rst_n), .SESSION_EST(sess), .CLOSE_REQ(creq),
    .CLOSE_ACK(close_ack), .TX_AFULL(afull), .TX_D(tx_d), .TX_B(tx_b),
    .CH_VALID(ch_valid), .CH_LAST(ch_last), .CH_D(ch_d), .CH_B(ch_b),
    .CH_READY(ch_ready), .GNT_ID(gnt_id), .GNT_ACT(gnt_act), .ERR_LEN(err_len)
  );

  typedef struct packed { logic [63:0] d; logic [3:0] b; logic last; } beat_t;
  beat_t mem [NCH][16];
  int head [NCH];
  int tail [NCH];
  logic [NCH-1:0] acc = '0;

  int checks = 0;
  int errors = 0;
  int dut_glog[$];
  logic [3:0]  dut_blog[$];
  logic [63:0] dut_dlog[$];
  logic prev_act = 1'b0;

  int m_mode, m_hold, m_last, m_beats, pick;
  logic [3:0]  m_tx_b, e_b;
  logic [63:0] m_tx_d, e_d;
  logic m_new, m_ack, m_err;
  logic [NCH-1:0] e_rdy;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_src();
    for (int c = 0; c < NCH; c++) begin
      if (head[c] < tail[c]) begin
        ch_valid[c]        = 1'b1;
        ch_last[c]         = mem[c][head[c]].last;
        ch_d[64*c +: 64]   = mem[c][head[c]].d;
        ch_b[4*c +: 4]     = mem[c][head[c]].b;
      end else begin
        ch_valid[c]        = 1'b0;
        ch_last[c]         = 1'b0;
        ch_d[64*c +: 64]   = '0;
        ch_b[4*c +: 4]     = '0;
      end
    end
  endtask

  task automatic push(input int c, input logic [63:0] d, input logic [3:0] b, input logic last);
    mem[c][tail[c]].d    = d;
    mem[c][tail[c]].b    = b;
    mem[c][tail[c]].last = last;
    tail[c]++;
    drive_src();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) if (acc[c]) head[c]++;
    drive_src();
  endtask

  task automatic flush(input int c);
    head[c] = tail[c];
    drive_src();
  endtask

  function automatic bit all_empty();
    for (int c = 0; c < NCH; c++) if (head[c] < tail[c]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input string nm, input int budget);
    int n;
    n = 0;
    while (!(all_empty() && !gnt_act) && n < budget) begin
      step();
      n++;
    end
    chk({nm, "_timeout"}, 64'(n >= budget), 64'd0);
    step();
    step();
  endtask

  task automatic chk_nib_log(input string nm, input int n, input logic [31:0] exp, input bit is_grant);
    chk({nm, "_len"}, 64'(is_grant ? dut_glog.size() : dut_blog.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (is_grant) begin
        if (i < dut_glog.size()) chk(nm, 64'(dut_glog[i]), 64'(exp[4*i +: 4]));
      end else begin
        if (i < dut_blog.size()) chk(nm, 64'(dut_blog[i]), 64'(exp[4*i +: 4]));
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      head[c] = 0;
      tail[c] = 0;
    end
    drive_src();
    step();
    step();
    chk("rst_tx_b", 64'(tx_b), 64'd0);
    chk("rst_tx_d", tx_d, 64'd0);
    chk("rst_gnt_act", 64'(gnt_act), 64'd0);
    chk("rst_close_ack", 64'(close_ack), 64'd0);
    chk("rst_err_len", 64'(err_len), 64'd0);
    chk("rst_ch_ready", 64'(ch_ready), 64'd0);
    rst_n = 1'b1;
    dut_glog.delete();
    dut_blog.delete();
    dut_dlog.delete();
  endtask

  // Reference model: evaluated between edges, predicts this cycle's outputs then the next state.
  initial begin
    forever begin
      @(negedge clk);
      acc = ch_valid & ch_ready;
      if (!rst_n) begin
        m_mode = M_IDLE; m_hold = -1; m_last = NCH - 1; m_beats = 0;
        m_tx_b = '0; m_tx_d = '0; m_new = 1'b0; m_ack = 1'b0; m_err = 1'b0;
        prev_act = 1'b0;
      end else begin
        if (gnt_act && !prev_act) dut_glog.push_back(int'(gnt_id));
        prev_act = gnt_act;
        if (tx_b != 4'd0) begin
          dut_blog.push_back(tx_b);
          dut_dlog.push_back(tx_d);
        end

        e_rdy = '0;
        if (m_mode == M_GRANT && ch_valid[m_hold] && !afull && sess && !creq) e_rdy[m_hold] = 1'b1;
        chk("ch_ready", 64'(ch_ready), 64'(e_rdy));
        chk("tx_b", 64'(tx_b), 64'(m_tx_b));
        if (m_new) chk("tx_d", tx_d, m_tx_d);
        chk("gnt_act", 64'(gnt_act), 64'(m_hold >= 0));
        if (m_hold >= 0) chk("gnt_id", 64'(gnt_id), 64'(m_hold));
        chk("close_ack", 64'(close_ack), 64'(m_ack));
        chk("err_len", 64'(err_len), 64'(m_err));

        if (e_rdy != '0) begin
          e_b = 4'(ch_b >> (4 * m_hold));
          e_d = 64'(ch_d >> (64 * m_hold));
          m_tx_b = (e_b > 4'd8) ? 4'd0 : e_b;
          m_tx_d = e_d;
          m_new  = 1'b1;
          if (e_b > 4'd8) m_err = 1'b1;
          m_beats++;
        end else begin
          m_tx_b = '0;
          m_new  = 1'b0;
        end

        if (!sess) begin
          m_mode = M_IDLE; m_hold = -1; m_beats = 0; m_ack = 1'b0;
        end else if (creq && (m_mode == M_IDLE || m_mode == M_GRANT)) begin
          m_mode = M_DRAIN; m_hold = -1; m_beats = 0;
        end else if (m_mode == M_IDLE) begin
          pick = -1;
          for (int k = 1; k <= NCH; k++)
            if (pick < 0 && ch_valid[(m_last + k) % NCH]) pick = (m_last + k) % NCH;
          if (pick >= 0) begin
            m_hold = pick;
            m_mode = M_GRANT;
          end
        end else if (m_mode == M_GRANT) begin
          if (e_rdy != '0 && (ch_last[m_hold] || m_beats == MB)) begin
            m_last = m_hold; m_hold = -1; m_beats = 0; m_mode = M_IDLE;
          end
        end else if (m_mode == M_DRAIN) begin
          m_mode = M_ACK; m_ack = 1'b1;
        end else if (m_mode == M_ACK && !creq) begin
          m_mode = M_IDLE; m_ack = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; sess = 1'b1; creq = 1'b0; afull = 1'b0;
    ch_valid = '0; ch_last = '0; ch_d = '0; ch_b = '0;

    // single channel, three full beats
    do_reset();
    push(0, 64'h101, 4'd8, 1'b0);
    push(0, 64'h102, 4'd8, 1'b0);
    push(0, 64'h103, 4'd8, 1'b1);
    wait_drain("t1", 40);
    chk_nib_log("t1_tx_b", 3, 32'h888, 1'b0);
    chk_nib_log("t1_gnt", 1, 32'h0, 1'b1);
    chk("t1_tx_d3", (dut_dlog.size() == 3) ? dut_dlog[2] : 64'd0, 64'h103);
    chk("t1_ptr_model", 64'(m_last), 64'd0);
    chk("t1_gnt_act", 64'(gnt_act), 64'd0);

    // four channels, two single-beat messages each
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NCH; c++) push(c, 64'h1000 + 64'(c * 256 + r), 4'(c + 1), 1'b1);
    wait_drain("t2", 80);
    chk_nib_log("t2_gnt", 8, 32'h32103210, 1'b1);
    chk_nib_log("t2_tx_b", 8, 32'h43214321, 1'b0);

    // burst quota forces re-arbitration
    do_reset();
    for (int k = 0; k < 10; k++) push(1, 64'h100 + 64'(k), 4'd8, k == 9);
    push(2, 64'h200, 4'd8, 1'b1);
    wait_drain("t3", 100);
    chk_nib_log("t3_gnt", 4, 32'h1121, 1'b1);
    chk("t3_len", 64'(dut_dlog.size()), 64'd11);
    if (dut_dlog.size() >= 6) begin
      chk("t3_d3", dut_dlog[3], 64'h103);
      chk("t3_d4", dut_dlog[4], 64'h200);
      chk("t3_d5", dut_dlog[5], 64'h104);
    end

    // almost-full stall mid-message
    do_reset();
    for (int k = 0; k < 4; k++) push(3, 64'h300 + 64'(k), 4'(k + 1), k == 3);
    for (int n = 0; n < 30 && head[3] < 2; n++) step();
    chk("t4_reach", 64'(head[3] >= 2), 64'd1);
    afull = 1'b1;
    step();
    chk("t4_stall_ready", 64'(ch_ready), 64'd0);
    chk("t4_stall_tx_b", 64'(tx_b), 64'd0);
    for (int n = 0; n < 4; n++) step();
    afull = 1'b0;
    wait_drain("t4", 40);
    chk_nib_log("t4_tx_b", 4, 32'h4321, 1'b0);
    chk("t4_d3", (dut_dlog.size() == 4) ? dut_dlog[3] : 64'd0, 64'h303);

    // close handshake during beat 2 of 5
    do_reset();
    for (int k = 0; k < 5; k++) push(0, 64'h500 + 64'(k), 4'd8, k == 4);
    for (int n = 0; n < 30 && head[0] < 1; n++) step();
    chk("t5_reach", 64'(head[0] >= 1), 64'd1);
    creq = 1'b1;
    #1;
    chk("t5_ready_drop", 64'(ch_ready), 64'd0);
    chk("t5_ack_early", 64'(close_ack), 64'd0);
    step();
    flush(0);
    chk("t5_ack_drain", 64'(close_ack), 64'd0);
    chk("t5_gnt_drop", 64'(gnt_act), 64'd0);
    step();
    chk("t5_ack_set", 64'(close_ack), 64'd1);
    step();
    chk("t5_ack_hold", 64'(close_ack), 64'd1);
    creq = 1'b0;
    step();
    chk("t5_ack_clear", 64'(close_ack), 64'd0);
    push(1, 64'h510, 4'd3, 1'b1);
    wait_drain("t5", 40);
    chk_nib_log("t5_gnt", 2, 32'h10, 1'b1);
    chk_nib_log("t5_tx_b", 2, 32'h38, 1'b0);

    // session loss mid-grant, with an oversize beat first
    do_reset();
    push(2, 64'h600, 4'd9, 1'b0);
    push(2, 64'h601, 4'd5, 1'b0);
    push(2, 64'h602, 4'd5, 1'b0);
    push(2, 64'h603, 4'd5, 1'b1);
    for (int n = 0; n < 30 && head[2] < 2; n++) step();
    chk("t6_reach", 64'(head[2] >= 2), 64'd1);
    sess = 1'b0;
    #1;
    chk("t6_ready_drop", 64'(ch_ready), 64'd0);
    step();
    chk("t6_gnt_act", 64'(gnt_act), 64'd0);
    chk("t6_err", 64'(err_len), 64'd1);
    chk("t6_tx_b", 64'(tx_b), 64'd0);
    for (int n = 0; n < 3; n++) step();
    chk("t6_err_hold", 64'(err_len), 64'd1);
    flush(2);
    sess = 1'b1;
    step();
    step();
    chk("t6_err_hold2", 64'(err_len), 64'd1);
    chk_nib_log("t6_tx_b", 1, 32'h5, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
